// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, defaults and parity helper
package uart_pkg;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_STOP2} rx_state_e;
    localparam int UART_OVS_DEFAULT = 16;
    function automatic logic par_calc(input logic [8:0] data, input logic odd);
        return ^data ^ odd;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clk tick every i_div+1 clocks
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] cnt;
    assign o_tick = cnt == i_div;
    always_ff @(posedge clk)
        cnt <= (!rstn || o_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with majority vote, parity/framing checks and a one-word holding register
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DLEN        = 8,
    parameter int OVS         = UART_OVS_DEFAULT,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_rxs,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_par_en,
    input  logic             i_par_odd,
    input  logic             i_stop2,
    output logic             o_rvalid,
    input  logic             i_rready,
    output logic [DLEN-1:0]  o_rdata,
    output logic             o_perr,
    output logic             o_ferr,
    output logic             o_ovf
);
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DLEN);
    localparam logic [SW-1:0] S_M0 = SW'(OVS/2-1);
    localparam logic [SW-1:0] S_M1 = SW'(OVS/2);
    localparam logic [SW-1:0] S_M2 = SW'(OVS/2+1);
    localparam logic [SW-1:0] S_END = SW'(OVS-1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs_s, tick, maj, s_a, s_b, at_maj, at_end, commit;
    logic                   par_en, par_odd, stop2, perr_q, ferr_q;
    logic [SW-1:0]          scnt;
    logic [BW-1:0]          bcnt;
    logic [DLEN-1:0]        shreg;
    rx_state_e              state;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk(clk),
        .rstn(rstn),
        .i_div(i_div),
        .o_tick(tick)
    );

    always_ff @(posedge clk)
        sync <= !rstn ? '1 : {sync[SYNC_STAGES-2:0], i_rxs};

    assign rxs_s  = sync[SYNC_STAGES-1];
    assign maj    = (s_a & s_b) | (s_a & rxs_s) | (s_b & rxs_s);
    assign at_maj = tick && scnt == S_M2;
    assign at_end = tick && scnt == S_END;
    // the last stop bit commits at its centre so the next start edge is never missed
    assign commit = at_maj && ((state == RX_STOP && !stop2) || state == RX_STOP2);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= RX_IDLE;
            scnt     <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            s_a      <= 1'b0;
            s_b      <= 1'b0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            stop2    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_perr   <= 1'b0;
            o_ferr   <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            if (tick && state != RX_IDLE) begin
                scnt <= scnt == S_END ? '0 : scnt + 1'b1;
                if (scnt == S_M0) s_a <= rxs_s;
                if (scnt == S_M1) s_b <= rxs_s;
            end
            case (state)
                RX_IDLE: if (tick && !rxs_s) begin
                    state   <= RX_START;
                    scnt    <= '0;
                    bcnt    <= '0;
                    par_en  <= i_par_en;
                    par_odd <= i_par_odd;
                    stop2   <= i_stop2;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                end
                RX_START: if (at_maj && maj) state <= RX_IDLE;
                          else if (at_end) state <= RX_DATA;
                RX_DATA: begin
                    if (at_maj) shreg <= {maj, shreg[DLEN-1:1]};
                    if (at_end) begin
                        bcnt <= bcnt + 1'b1;
                        if (bcnt == BW'(DLEN-1)) state <= par_en ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (at_maj) perr_q <= par_calc(9'(shreg), par_odd) ^ maj;
                    if (at_end) state <= RX_STOP;
                end
                RX_STOP: begin
                    if (at_maj) ferr_q <= ferr_q | !maj;
                    if (commit) state <= RX_IDLE;
                    else if (at_end) state <= RX_STOP2;
                end
                RX_STOP2: if (commit) state <= RX_IDLE;
                default: state <= RX_IDLE;
            endcase
            o_ovf <= commit && o_rvalid && !i_rready;
            if (commit && (!o_rvalid || i_rready)) begin
                o_rvalid <= 1'b1;
                o_rdata  <= shreg;
                o_perr   <= perr_q;
                o_ferr   <= ferr_q | !maj;
            end else if (i_rready) begin
                o_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: table, directed and randomized frame checks of uart_rx_cfg against a frame-level model
module tb_uart_rx_cfg;
    localparam int OVS = 16;

    logic        clk = 1'b0, rstn = 1'b0, i_rxs = 1'b1, i_rready = 1'b1;
    logic        i_par_en = 1'b0, i_par_odd = 1'b0, i_stop2 = 1'b0;
    logic [15:0] i_div = 16'd3;
    logic        o_rvalid, o_perr, o_ferr, o_ovf;
    logic [7:0]  o_rdata;

    int          n_vec = 0, n_err = 0, cyc = 0, cyc_r = 0, rise_cyc = -1, ovf_cnt = 0;
    logic        rv_prev = 1'b0;
    logic [9:0]  rxq[$];

    typedef struct {
        logic [7:0] data;
        bit pe, po, pb, st2, s1, s2;
        logic [7:0] e_data;
        bit e_perr, e_ferr;
    } vec_t;
    vec_t tbl[12];

    uart_rx_cfg dut (
        .clk(clk), .rstn(rstn), .i_rxs(i_rxs), .i_div(i_div),
        .i_par_en(i_par_en), .i_par_odd(i_par_odd), .i_stop2(i_stop2),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata),
        .o_perr(o_perr), .o_ferr(o_ferr), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (o_rvalid && i_rready) rxq.push_back({o_rdata, o_perr, o_ferr});
            if (o_ovf) ovf_cnt++;
            if (o_rvalid && !rv_prev) rise_cyc = cyc;
        end
        rv_prev = o_rvalid;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int blen();
        return OVS * (int'(i_div) + 1);
    endfunction

    // start is seen on the first tick at least 3 clocks after the edge; ticks fall every div+1 clocks from reset release
    function automatic int exp_commit(input int c0, input int final_bit);
        int p = int'(i_div) + 1;
        int t = c0 + 3;
        while ((t - cyc_r) % p != 0) t++;
        return t + (final_bit * OVS + OVS/2 + 2) * p;
    endfunction

    function automatic logic [9:0] model(input logic [7:0] d, input bit pe, po, pb, st2, s1, s2);
        bit p = pe && (((($countones(d) + int'(pb)) % 2) == 1) != po);
        bit f = !s1 || (st2 && !s2);
        return {d, p, f};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input string name, input logic [9:0] e);
        logic [9:0] w;
        int t = 0;
        while (rxq.size() == 0 && t < 12 * blen()) begin step(1); t++; end
        n_vec++;
        if (rxq.size() == 0) begin
            n_err++;
            $display("FAIL %s: no word delivered, expected data=%02h perr=%0b ferr=%0b", name, e[9:2], e[1], e[0]);
        end else begin
            w = rxq.pop_front();
            if (w !== e) begin
                n_err++;
                $display("FAIL %s: got data=%02h perr=%0b ferr=%0b, expected data=%02h perr=%0b ferr=%0b",
                         name, w[9:2], w[1], w[0], e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic expect_none(input string name);
        n_vec++;
        if (rxq.size() != 0) begin
            n_err++;
            $display("FAIL %s: got %0d unexpected words (first data=%02h), expected none", name, rxq.size(), rxq[0][9:2]);
            rxq.delete();
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_rvalid"}, int'(o_rvalid), 0);
        chk({name, "_rdata"}, int'(o_rdata), 0);
        chk({name, "_perr"}, int'(o_perr), 0);
        chk({name, "_ferr"}, int'(o_ferr), 0);
        chk({name, "_ovf"}, int'(o_ovf), 0);
    endtask

    // config is scrambled after the start bit to show the frame keeps the settings it started with
    task automatic send_frame(input logic [7:0] d, input bit pe, po, pb, st2, s1, s2, input int spike);
        bit q[$];
        int b;
        b = blen();
        {i_par_en, i_par_odd, i_stop2} = {pe, po, st2};
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back(pb);
        q.push_back(s1);
        if (st2) q.push_back(s2);
        foreach (q[i]) begin
            i_rxs = q[i];
            if (i == 1) {i_par_en, i_par_odd, i_stop2} = 3'($urandom);
            if (i == spike) begin
                step(b / 2);
                i_rxs = !q[i];
                step(b / OVS);
                i_rxs = q[i];
                step(b - b / 2 - b / OVS);
            end else begin
                step(b);
            end
        end
        i_rxs = 1'b1;
        {i_par_en, i_par_odd, i_stop2} = {pe, po, st2};
    endtask

    task automatic idle(input int nbits);
        i_rxs = 1'b1;
        step(nbits * blen());
    endtask

    initial begin
        int c0, ec;
        bit pe, po, pb, st2, s1, s2;
        logic [7:0] d;
        tbl[0]  = '{8'hA5, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
        tbl[1]  = '{8'h37, 1, 0, 1, 0, 1, 1, 8'h37, 0, 0};
        tbl[2]  = '{8'h37, 1, 0, 0, 0, 1, 1, 8'h37, 1, 0};
        tbl[3]  = '{8'h37, 1, 1, 0, 0, 1, 1, 8'h37, 0, 0};
        tbl[4]  = '{8'h37, 1, 1, 1, 0, 1, 1, 8'h37, 1, 0};
        tbl[5]  = '{8'hC3, 0, 0, 0, 0, 0, 1, 8'hC3, 0, 1};
        tbl[6]  = '{8'h5A, 0, 0, 0, 1, 1, 0, 8'h5A, 0, 1};
        tbl[7]  = '{8'h81, 0, 0, 0, 1, 1, 1, 8'h81, 0, 0};
        tbl[8]  = '{8'hFF, 1, 0, 0, 0, 0, 1, 8'hFF, 0, 1};
        tbl[9]  = '{8'h00, 1, 1, 0, 1, 1, 1, 8'h00, 1, 0};
        tbl[10] = '{8'h6C, 0, 0, 0, 1, 0, 1, 8'h6C, 0, 1};
        tbl[11] = '{8'h01, 1, 1, 0, 1, 1, 1, 8'h01, 0, 0};

        step(4);
        chk_reset_outs("por");
        cyc_r = cyc;
        rstn = 1'b1;
        idle(1);

        // 8N1 latency: o_rvalid rises the clk after the stop-bit majority tick
        rise_cyc = -1;
        c0 = cyc;
        ec = exp_commit(c0, 9);
        send_frame(8'hA5, 0, 0, 0, 0, 1, 1, -1);
        expect_word("lat_a5", {8'hA5, 2'b00});
        chk("lat_a5_cycle", rise_cyc, ec);
        chk("lat_a5_pulse", int'(o_rvalid), 0);
        idle(1);

        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].pe, tbl[i].po, tbl[i].pb, tbl[i].st2, tbl[i].s1, tbl[i].s2, -1);
            idle(1);
            expect_word($sformatf("tbl%0d", i), {tbl[i].e_data, tbl[i].e_perr, tbl[i].e_ferr});
        end

        {i_par_en, i_par_odd, i_stop2} = 3'b000;
        i_rxs = 1'b0;
        step(2 * (int'(i_div) + 1));
        idle(2);
        expect_none("glitch");
        send_frame(8'h5A, 0, 0, 0, 0, 1, 1, 3);
        idle(1);
        expect_word("spike_5a", {8'h5A, 2'b00});

        // a long break delivers 0x00 with ferr, then the tail restarts a frame that sees 0xFE
        i_rxs = 1'b0;
        step(12 * blen());
        i_rxs = 1'b1;
        expect_word("break", {8'h00, 2'b01});
        expect_word("break_tail", {8'hFE, 2'b00});
        idle(2);

        ovf_cnt = 0;
        i_rready = 1'b0;
        send_frame(8'h11, 0, 0, 0, 0, 1, 1, -1);
        send_frame(8'h22, 0, 0, 0, 0, 1, 1, -1);
        idle(1);
        chk("ovf_rvalid", int'(o_rvalid), 1);
        chk("ovf_hold", int'(o_rdata), 'h11);
        chk("ovf_once", ovf_cnt, 1);
        i_rready = 1'b1;
        step(1);
        i_rready = 1'b0;
        expect_word("drain11", {8'h11, 2'b00});
        chk("drain_rvalid", int'(o_rvalid), 0);
        send_frame(8'h33, 0, 0, 0, 0, 1, 1, -1);
        idle(1);
        c0 = cyc;
        ec = exp_commit(c0, 9);
        fork
            send_frame(8'h44, 0, 0, 0, 0, 1, 1, -1);
            begin
                step(ec - 1 - c0);
                i_rready = 1'b1;
                step(1);
                i_rready = 1'b0;
            end
        join
        idle(1);
        chk("replace_rvalid", int'(o_rvalid), 1);
        chk("replace_data", int'(o_rdata), 'h44);
        chk("replace_no_ovf", ovf_cnt, 1);
        expect_word("hs33", {8'h33, 2'b00});
        expect_none("hs_only33");
        i_rready = 1'b1;
        expect_word("drain44", {8'h44, 2'b00});
        idle(1);

        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            {pe, po, st2} = 3'($urandom);
            pb = 1'($urandom);
            s1 = $urandom_range(0, 4) != 0;
            s2 = $urandom_range(0, 4) != 0;
            send_frame(d, pe, po, pb, st2, s1, s2, -1);
            idle((!s1 || (st2 && !s2)) ? 1 : $urandom_range(0, 1));
            expect_word($sformatf("rnd_a%0d", i), model(d, pe, po, pb, st2, s1, s2));
        end

        fork
            send_frame(8'h99, 0, 0, 0, 0, 1, 1, -1);
            begin
                step(4 * blen());
                rstn = 1'b0;
                step(2);
                chk_reset_outs("midrst");
            end
        join
        i_div = 16'd5;
        step(blen());
        cyc_r = cyc;
        rstn = 1'b1;
        idle(1);
        rise_cyc = -1;
        c0 = cyc;
        ec = exp_commit(c0, 9);
        send_frame(8'h3C, 0, 0, 0, 0, 1, 1, -1);
        idle(1);
        expect_word("post_rst_3c", {8'h3C, 2'b00});
        chk("lat_3c_cycle", rise_cyc, ec);
        expect_none("post_rst_only");

        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            {pe, po, st2} = 3'($urandom);
            pb = 1'($urandom);
            s1 = $urandom_range(0, 4) != 0;
            s2 = $urandom_range(0, 4) != 0;
            send_frame(d, pe, po, pb, st2, s1, s2, -1);
            idle((!s1 || (st2 && !s2)) ? 1 : $urandom_range(0, 1));
            expect_word($sformatf("rnd_b%0d", i), model(d, pe, po, pb, st2, s1, s2));
        end
        idle(2);
        expect_none("final_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Second-generation UART receiver. Runtime-programmable baud divisor, 16x oversampling with 3-sample majority vote, optional even/odd parity, and 1 or 2 stop bits.
- Reports per-word parity and framing errors.
- Delivers words over a valid/ready interface with a one-entry holding register and an overflow indication.
- Sits between the pad-side serial input and the UART register/FIFO layer.

Parameters:
- DLEN, 8: data bits per frame, range 5..9.
- OVS, 16: oversample ticks per bit, even, at least 8.
- DIV_W, 16: width of the divisor input.
- SYNC_STAGES, 2: input synchroniser depth, at least 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- i_rxs  in  1  asynchronous serial input, idle high.
- i_div  in  DIV_W  clocks per oversample tick minus 1.
- i_par_en  in  1  parity bit present.
- i_par_odd  in  1  1 = odd parity, 0 = even parity.
- i_stop2  in  1  two stop bits.
- o_rvalid  out  1  holding register contains a word.
- i_rready  in  1  consumer accepts the word.
- o_rdata  out  DLEN  received word, LSB first on the line.
- o_perr  out  1  parity error for o_rdata; qualified by o_rvalid.
- o_ferr  out  1  framing error for o_rdata; qualified by o_rvalid.
- o_ovf  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset rstn, synchronous, active-low; clock clk.
- Reset values: o_rvalid=0, o_rdata=0, o_perr=0, o_ferr=0, o_ovf=0. Synchroniser flops reset to 1. FSM resets to IDLE. All counters reset to 0.
- Reset mid-frame abandons the frame; nothing is delivered.
- Synchroniser: i_rxs passes through SYNC_STAGES flops. All logic below uses the synchronised value rxs_s.
- Tick generator:
  - Free-running counter 0..i_div; tick is high for one clk when counter == i_div, then the counter wraps to 0.
  - i_div=0 gives a tick every clk.
  - If i_div changes below the current count, the counter wraps at DIV_W overflow. Software changes i_div only while the line is idle.
- Sample counter: counts ticks 0..OVS-1 within a bit; wraps at OVS-1 and advances to the next bit.
- Majority: the bit value is the majority of rxs_s at ticks OVS/2-1, OVS/2 and OVS/2+1. It is valid after tick OVS/2+1.
- Config: i_par_en, i_par_odd and i_stop2 are latched on entry to START. Changes mid-frame have no effect on that frame.
- FSM:
  - IDLE: on a tick with rxs_s=0 -> START, sample counter=0.
  - START: at the majority point, majority=1 -> IDLE (glitch rejected, no output, no error). Otherwise stay to the end of the bit, then -> DATA.
  - DATA: shift the majority value into the MSB of the shift register at each majority point (LSB-first line order). After DLEN bits, at end of bit -> PARITY if par_en, else STOP.
  - PARITY: perr_q = (XOR of data bits XOR parity bit) XOR par_odd. Pass requires an even count of ones including the parity bit for even parity, odd for odd parity. End of bit -> STOP.
  - STOP: majority=0 sets ferr_q. If stop2 and this is the first stop bit, go to end of bit, then -> STOP2.
  - STOP2: same check as STOP.
  - The final stop bit commits the frame at its majority point and goes to IDLE immediately. This allows back-to-back frames and tolerates up to half a bit of clock mismatch.
- A break (all-zero line) is delivered as data 0 with o_ferr=1.
- Commit (1-clk strobe):
  - Holding register empty, or o_rvalid && i_rready in the same cycle: load o_rdata/o_perr/o_ferr. o_rvalid=1 on the next clk.
  - o_rvalid && !i_rready: drop the new frame, o_ovf=1 for one clk. The held word is unchanged.
- Handshake: o_rvalid && i_rready with no commit clears o_rvalid next clk. o_rdata is stable while o_rvalid && !i_rready.
- Latency: o_rvalid rises 1 clk after the majority tick (OVS/2+1) of the final stop bit.

Decomposition:
- Package uart_pkg holds:
  - rx_state_e enum {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_STOP2};
  - localparam UART_OVS_DEFAULT=16;
  - a function par_calc(data, odd).
- Sub-module uart_baud_tick (parameter DIV_W; ports clk, rstn, i_div, o_tick). A future uart_tx_cfg reuses it.

Test Plan:
- DLEN=8, OVS=16, i_div=3 (64 clk/bit), 8N1, send 0xA5, i_rready=1 -> one o_rvalid pulse with o_rdata=0xA5, o_perr=0, o_ferr=0, at the expected clk after the stop-bit majority tick.
- Even parity: send 0x37 with parity bit 1 -> o_rdata=0x37, perr=0. Send 0x37 with parity bit 0 -> perr=1. Odd parity with parity bit 0 -> perr=0.
- Stop bit forced 0 -> o_ferr=1 with correct data. With i_stop2=1 and the second stop bit 0 -> o_ferr=1. Line held low for 12 bits -> o_rdata=0x00, o_ferr=1.
- 2-tick low glitch on an idle line, and a single-tick spike mid-bit during 0x5A -> no word for the first; 0x5A received correctly for the second (majority vote).
- i_rready=0, send 0x11 then 0x22 back-to-back -> o_rdata holds 0x11 and o_ovf pulses once at the 0x22 commit. With i_rready=1 in the commit cycle -> 0x22 replaces 0x11 and o_rvalid stays high.
- rstn asserted mid-DATA then released, then send 0x3C -> no partial word; 0x3C received. All outputs 0 during reset.
